bcd_fib_inv: RTL and testbench
==============================

# bcd_fib_inv

Inverse Fibonacci search with BCD I/O. It is the counterpart of the team's BCD Fibonacci calculator: that block takes an index and produces a value, and this block takes a value and returns an index. The input is a 4-digit BCD value x (0–9999). The block returns the largest index n with fib(n) ≤ x, as two BCD digits, plus a flag that says whether x is itself a Fibonacci number. It sits beside the calculator in the same datapath and uses the same start/ready/done_tick handshake, so a master FSM can sequence it.

## Interface
Parameters:
- none; all widths and constants are fixed and defined in the shared package.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state while low.
- start  in  1  request pulse; sampled only in idle.
- bcd3, bcd2, bcd1, bcd0  in  4 each  input value x, digit 3 most significant.
- ready  out  1  high while in idle.
- done_tick  out  1  one-cycle pulse when a result becomes valid.
- out_bcd1, out_bcd0  out  4 each  index n as two BCD digits, range 00–20.
- exact  out  1  fib(n) == x.
- err  out  1  an input digit was greater than 9.

## Operation
Definitions:
- fib(0)=0, fib(1)=1, fib(i)=fib(i-1)+fib(i-2).
- Worked values: x=0 gives n=0; x=1 gives n=2; x=9999 gives n=20 (fib(20)=6765).

FSM states: idle, conv, search, done.
- **idle**
  - ready=1.
  - When start=1: latch all four digits, clear the accumulator, enter conv.
  - Input changes after the latch have no effect on the running operation.
- **conv** (exactly 4 cycles)
  - One digit per cycle, most significant first: acc ← acc×10 + digit.
  - acc is 14 bits wide.
  - Any latched digit greater than 9 sets a sticky invalid flag.
  - After the 4th cycle:
    - invalid flag set: go to done with err=1.
    - otherwise: initialise t0=0, t1=1, n=0 and go to search.
- **search** (one iteration per cycle)
  - If t1 ≤ acc: t0 ← t1, t1 ← t0+t1, n ← n+1.
  - Otherwise: capture the result and go to done.
  - Result capture:
    - out_bcd1 = n/10, out_bcd0 = n%10, using compare/subtract (n ≤ 20, no divider).
    - exact = (t0 == acc).
    - err = 0.
- **done** (1 cycle)
  - done_tick=1, then return to idle.

Arithmetic and widths:
- t0 and t1 are 15 bits unsigned, so the sum never exceeds fib(21)=10946.
- n is 5 bits.
- All comparisons are unsigned.

Outputs:
- Reset values: out_bcd1=0, out_bcd0=0, exact=0, err=0, done_tick=0, ready=1 (state=idle).
- Result outputs are registered and hold their value until the next result is captured.
- On an err result: out_bcd1=0, out_bcd0=0, exact=0.

Boundary conditions:
- start while not idle: ignored, no queuing.
- start held high: one operation per idle visit.
  - A new operation starts on the first idle cycle after done.
- reset low at any point: immediate return to idle and all outputs at reset values.
  - No done_tick is produced for the aborted operation.
- A glitch-free return is required even mid-conv or mid-search.

## Timing
- Reference point: the edge that samples start in idle.
- Valid input: done_tick is high in the cycle beginning n+6 rising edges after that edge.
  - Made up of 4 conv cycles, n+1 search cycles, and the done cycle.
  - Minimum latency 6 (x=0); maximum 26 (x ≥ 6765).
- Invalid input: done_tick 5 edges after the start-sampling edge.
- Result outputs are valid in the same cycle done_tick is high.
- ready falls on the edge after start is sampled and rises on the edge after done.
- Back-to-back operations: the shortest start-to-start spacing is n+7 cycles.

## Structure
Shared package contents:
- State encoding (2-bit localparams: idle, conv, search, done).
- Width constants: value width 14, Fibonacci register width 15, index width 5.
- MAX_IDX=20.

Natural sub-module:
- bcd4_to_bin: sequential 4-digit converter with start/done_tick and an invalid output.
- It is usable elsewhere in the codebase.
- The top-level FSM owns search, index-to-BCD conversion and output registers.

## Test plan
- x=0000 → out=00, exact=1, err=0; done_tick 6 edges after start.
- x=0001 → out=02, exact=1.
- x=0013 → out=07, exact=1.
- x=0100 → out=11, exact=0 (89 ≤ 100 < 144); done_tick at 17 edges.
- x=6765 → out=20, exact=1. x=9999 → out=20, exact=0; done_tick at 26 edges.
- bcd1=4'hA → err=1, out=00, exact=0; done_tick at 5 edges.
- Reset pulsed low mid-search on x=9999 → outputs cleared at once and ready=1.
  - No done_tick follows.
  - A subsequent start with x=0021 gives out=08, exact=1.
- start re-pulsed during search → ignored; the first result is unaffected.
- start held high across two operations → exactly two done_ticks, spaced n+7 cycles apart.

Source files
------------

// File: rtl/bcd_fib_inv_pkg.sv
// Shared definitions for the inverse-Fibonacci block and its BCD front end.
// Holds the FSM state encodings, the datapath widths and a digit-check helper.
package bcd_fib_inv_pkg;

    // Binary value converted from four BCD digits (0..9999 fits in 14 bits).
    localparam int unsigned VAL_W      = 14;
    // Fibonacci pair registers; must hold fib(21) = 10946.
    localparam int unsigned FIB_W      = 15;
    // Result index width.
    localparam int unsigned IDX_W      = 5;
    // Largest index the search can return for a 4-digit input.
    localparam int unsigned MAX_IDX    = 20;
    localparam int unsigned NUM_DIGITS = 4;

    // Top-level FSM.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StConv   = 2'd1,
        StSearch = 2'd2,
        StDone   = 2'd3
    } state_e;

    // BCD-to-binary converter FSM.
    typedef enum logic [0:0] {
        CvtIdle = 1'b0,
        CvtConv = 1'b1
    } cvt_state_e;

    // A BCD digit above 9 is not a legal decimal digit.
    function automatic logic digit_invalid(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_fib_inv_bcd4_to_bin.sv
// Sequential 4-digit BCD to binary converter.
// On start (while idle) the four digits are latched and folded in, most
// significant first, one per cycle: acc <- acc*10 + digit.  done_tick is high
// during the fourth conversion cycle; value/invalid carry the final result in
// that same cycle so a consumer can register them on the following edge.
// Ports:
//   clk, reset (async, active-low)
//   start                 request, sampled only while idle
//   bcd3..bcd0            input digits, bcd3 most significant
//   done_tick             one-cycle pulse, result valid on value/invalid
//   value [VAL_W-1:0]     converted binary value
//   invalid               some latched digit was greater than 9
module bcd_fib_inv_bcd4_to_bin
    import bcd_fib_inv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       bcd3,
    input  logic [3:0]       bcd2,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd0,
    output logic             done_tick,
    output logic [VAL_W-1:0] value,
    output logic             invalid
);

    cvt_state_e       state_q, state_d;
    logic [15:0]      digits_q, digits_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             invalid_q, invalid_d;

    logic [3:0]       cur_digit;
    logic [VAL_W-1:0] acc_next;
    logic             invalid_next;

    // Digits are shifted out of the top nibble, so the current digit is fixed.
    assign cur_digit    = digits_q[15:12];
    // Illegal digits may wrap the 14-bit accumulator; the result is flagged anyway.
    assign acc_next     = acc_q * VAL_W'(10) + {{(VAL_W - 4){1'b0}}, cur_digit};
    assign invalid_next = invalid_q | digit_invalid(cur_digit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CvtIdle;
            digits_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            invalid_q <= invalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        invalid_d = invalid_q;
        unique case (state_q)
            CvtIdle: begin
                if (start) begin
                    digits_d  = {bcd3, bcd2, bcd1, bcd0};
                    acc_d     = '0;
                    cnt_d     = '0;
                    invalid_d = 1'b0;
                    state_d   = CvtConv;
                end
            end
            CvtConv: begin
                acc_d     = acc_next;
                invalid_d = invalid_next;
                digits_d  = {digits_q[11:0], 4'h0};
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == 2'(NUM_DIGITS - 1)) begin
                    state_d = CvtIdle;
                end
            end
            default: state_d = CvtIdle;
        endcase
    end

    assign done_tick = (state_q == CvtConv) && (cnt_q == 2'(NUM_DIGITS - 1));
    assign value     = acc_next;
    assign invalid   = invalid_next;

endmodule

// File: rtl/bcd_fib_inv.sv
// Inverse Fibonacci search with BCD I/O.
// Returns the largest n with fib(n) <= x for a 4-digit BCD input x, as two
// BCD digits, and flags whether x is itself a Fibonacci number.
// Ports:
//   clk, reset (async, active-low)
//   start                   request pulse, sampled only while idle
//   bcd3..bcd0              input value x, bcd3 most significant
//   ready                   high while idle
//   done_tick               one-cycle pulse when the result becomes valid
//   out_bcd1, out_bcd0      index n as two BCD digits (00..20)
//   exact                   fib(n) == x
//   err                     an input digit was greater than 9
module bcd_fib_inv
    import bcd_fib_inv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    output logic       ready,
    output logic       done_tick,
    output logic [3:0] out_bcd1,
    output logic [3:0] out_bcd0,
    output logic       exact,
    output logic       err
);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic [FIB_W-1:0] t0_q, t0_d;
    logic [FIB_W-1:0] t1_q, t1_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [3:0]       out_bcd1_q, out_bcd1_d;
    logic [3:0]       out_bcd0_q, out_bcd0_d;
    logic             exact_q, exact_d;
    logic             err_q, err_d;

    logic             cvt_start;
    logic             cvt_done;
    logic [VAL_W-1:0] cvt_value;
    logic             cvt_invalid;

    logic             fib_le;
    logic [3:0]       idx_tens;
    logic [IDX_W-1:0] idx_ones;

    bcd_fib_inv_bcd4_to_bin u_cvt (
        .clk       (clk),
        .reset     (reset),
        .start     (cvt_start),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .done_tick (cvt_done),
        .value     (cvt_value),
        .invalid   (cvt_invalid)
    );

    // t0/t1 track fib(n)/fib(n+1); advance while the next term still fits.
    assign fib_le = t1_q <= {1'b0, acc_q};

    // n never exceeds MAX_IDX, so two compare/subtract steps give n/10 and n%10.
    always_comb begin
        if (n_q >= IDX_W'(MAX_IDX)) begin
            idx_tens = 4'd2;
            idx_ones = n_q - IDX_W'(20);
        end else if (n_q >= IDX_W'(10)) begin
            idx_tens = 4'd1;
            idx_ones = n_q - IDX_W'(10);
        end else begin
            idx_tens = 4'd0;
            idx_ones = n_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            n_q        <= '0;
            out_bcd1_q <= '0;
            out_bcd0_q <= '0;
            exact_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            n_q        <= n_d;
            out_bcd1_q <= out_bcd1_d;
            out_bcd0_q <= out_bcd0_d;
            exact_q    <= exact_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StConv;
            end
            StConv: begin
                if (cvt_done) state_d = cvt_invalid ? StDone : StSearch;
            end
            StSearch: begin
                if (!fib_le) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values.
    always_comb begin
        acc_d      = acc_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        n_d        = n_q;
        out_bcd1_d = out_bcd1_q;
        out_bcd0_d = out_bcd0_q;
        exact_d    = exact_q;
        err_d      = err_q;
        unique case (state_q)
            StConv: begin
                if (cvt_done) begin
                    if (cvt_invalid) begin
                        out_bcd1_d = '0;
                        out_bcd0_d = '0;
                        exact_d    = 1'b0;
                        err_d      = 1'b1;
                    end else begin
                        acc_d = cvt_value;
                        t0_d  = '0;
                        t1_d  = FIB_W'(1);
                        n_d   = '0;
                    end
                end
            end
            StSearch: begin
                if (fib_le) begin
                    t0_d = t1_q;
                    t1_d = t0_q + t1_q;
                    n_d  = n_q + IDX_W'(1);
                end else begin
                    out_bcd1_d = idx_tens;
                    out_bcd0_d = idx_ones[3:0];
                    exact_d    = (t0_q == {1'b0, acc_q});
                    err_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        ready     = (state_q == StIdle);
        done_tick = (state_q == StDone);
        cvt_start = (state_q == StIdle) && start;
    end

    assign out_bcd1 = out_bcd1_q;
    assign out_bcd0 = out_bcd0_q;
    assign exact    = exact_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_fib_inv.sv
// Self-checking bench for bcd_fib_inv. Latencies are counted in rising edges
// with the edge that samples start counted as edge 1.
module tb_bcd_fib_inv;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
    logic       ready, done_tick, exact, err;
    logic [3:0] out_bcd1, out_bcd0;

    int errors = 0;
    int checks = 0;

    bcd_fib_inv dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .ready     (ready),
        .done_tick (done_tick),
        .out_bcd1  (out_bcd1),
        .out_bcd0  (out_bcd0),
        .exact     (exact),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: decimal value, Fibonacci table scan, latency formula.
    task automatic model(input logic [15:0] xb, output logic [3:0] et, output logic [3:0] eo,
                         output logic eex, output logic eer, output int elat);
        int fib [0:21];
        int x;
        int n;
        int d [4];
        d[0] = int'(xb[15:12]);
        d[1] = int'(xb[11:8]);
        d[2] = int'(xb[7:4]);
        d[3] = int'(xb[3:0]);
        if (d[0] > 9 || d[1] > 9 || d[2] > 9 || d[3] > 9) begin
            et = 0; eo = 0; eex = 0; eer = 1; elat = 5;
        end else begin
            x = d[0] * 1000 + d[1] * 100 + d[2] * 10 + d[3];
            fib[0] = 0;
            fib[1] = 1;
            for (int i = 2; i <= 21; i++) fib[i] = fib[i-1] + fib[i-2];
            n = 0;
            for (int i = 0; i <= 21; i++) if (fib[i] <= x) n = i;
            et   = 4'(n / 10);
            eo   = 4'(n % 10);
            eex  = (fib[n] == x);
            eer  = 0;
            elat = n + 6;
        end
    endtask

    // Issue one operation and wait (bounded) for done_tick.
    task automatic do_op(input logic [15:0] xb, output int lat, output logic rdy_after,
                         output logic [3:0] t, output logic [3:0] o,
                         output logic ex, output logic er);
        @(negedge clk);
        {bcd3, bcd2, bcd1, bcd0} = xb;
        start = 1'b1;
        lat = -1;
        rdy_after = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start = 1'b0;
                rdy_after = ready;
                {bcd3, bcd2, bcd1, bcd0} = 16'h9999 ^ xb;
            end
            if (done_tick) begin
                lat = i;
                break;
            end
        end
        t = out_bcd1;
        o = out_bcd0;
        ex = exact;
        er = err;
        @(negedge clk);
    endtask

    task automatic run_and_check(input logic [15:0] xb, input string name);
        logic [3:0] t, o, et, eo;
        logic ex, er, eex, eer, rdy;
        int lat, elat;
        model(xb, et, eo, eex, eer, elat);
        do_op(xb, lat, rdy, t, o, ex, er);
        checks++;
        if ({t, o} !== {et, eo}) begin
            errors++;
            $display("FAIL %s x=%h index: got %h%h expected %h%h", name, xb, t, o, et, eo);
        end
        checks++;
        if ({ex, er} !== {eex, eer}) begin
            errors++;
            $display("FAIL %s x=%h exact/err: got %b%b expected %b%b", name, xb, ex, er, eex, eer);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL %s x=%h latency: got %0d expected %0d", name, xb, lat, elat);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s x=%h ready after start: got %b expected 0", name, xb, rdy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({ready, done_tick, out_bcd1, out_bcd0, exact, err} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b dt=%b out=%h%h ex=%b err=%b expected 1 0 00 0 0",
                     ready, done_tick, out_bcd1, out_bcd0, exact, err);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] vec [9] = '{16'h0000, 16'h0001, 16'h0013, 16'h0100, 16'h6765,
                                 16'h9999, 16'h0021, 16'h0002, 16'h0143};
        for (int i = 0; i < 9; i++) run_and_check(vec[i], "directed");
    endtask

    task automatic test_invalid();
        run_and_check(16'h00A0, "invalid_bcd1");
        run_and_check(16'hF999, "invalid_bcd3");
        // Valid result after an error must clear err.
        run_and_check(16'h0055, "after_invalid");
    endtask

    task automatic test_random();
        logic [15:0] xb;
        for (int k = 0; k < 25; k++) begin
            for (int j = 0; j < 4; j++) begin
                xb = xb << 4;
                if ($urandom_range(0, 15) == 0) xb[3:0] = 4'($urandom_range(10, 15));
                else xb[3:0] = 4'($urandom_range(0, 9));
            end
            run_and_check(xb, "random");
        end
    endtask

    task automatic test_reset_mid_search();
        int dt_cnt;
        run_and_check(16'h6765, "pre_reset");
        @(negedge clk);
        {bcd3, bcd2, bcd1, bcd0} = 16'h9999;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({ready, done_tick, out_bcd1, out_bcd0, exact, err} !== {1'b1, 1'b0, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_search: got rdy=%b dt=%b out=%h%h ex=%b err=%b expected 1 0 00 0 0",
                     ready, done_tick, out_bcd1, out_bcd0, exact, err);
        end
        @(negedge clk);
        reset = 1'b1;
        dt_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done_tick) dt_cnt++;
        end
        checks++;
        if (dt_cnt != 0) begin
            errors++;
            $display("FAIL aborted_done_tick: got %0d pulses expected 0", dt_cnt);
        end
        run_and_check(16'h0021, "after_reset");
    endtask

    task automatic test_start_during_search();
        int lat;
        int dt_cnt;
        logic [3:0] t, o;
        logic ex;
        @(negedge clk);
        {bcd3, bcd2, bcd1, bcd0} = 16'h0100;
        start = 1'b1;
        lat = -1;
        dt_cnt = 0;
        t = '0;
        o = '0;
        ex = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
            if (i == 8) begin
                {bcd3, bcd2, bcd1, bcd0} = 16'h9999;
                start = 1'b1;
            end
            if (i == 9) start = 1'b0;
            if (done_tick) begin
                dt_cnt++;
                if (lat < 0) begin
                    lat = i;
                    {t, o, ex} = {out_bcd1, out_bcd0, exact};
                end
            end
        end
        checks++;
        if ({t, o, ex} !== {8'h11, 1'b0}) begin
            errors++;
            $display("FAIL start_in_search result: got %h%h ex=%b expected 11 ex=0", t, o, ex);
        end
        checks++;
        if (lat != 17 || dt_cnt != 1) begin
            errors++;
            $display("FAIL start_in_search timing: got lat=%0d pulses=%0d expected lat=17 pulses=1",
                     lat, dt_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int pos [2];
        int dt_cnt;
        logic [3:0] et, eo;
        logic eex, eer;
        int elat;
        model(16'h0013, et, eo, eex, eer, elat);
        @(negedge clk);
        {bcd3, bcd2, bcd1, bcd0} = 16'h0013;
        start = 1'b1;
        dt_cnt = 0;
        pos[0] = -1;
        pos[1] = -1;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk);
            #1;
            if (done_tick) begin
                if (dt_cnt < 2) pos[dt_cnt] = i;
                dt_cnt++;
                if (dt_cnt == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (dt_cnt != 2) begin
            errors++;
            $display("FAIL back_to_back count: got %0d expected 2", dt_cnt);
        end
        checks++;
        if (pos[0] != elat || pos[1] - pos[0] != elat + 1) begin
            errors++;
            $display("FAIL back_to_back spacing: got first=%0d gap=%0d expected first=%0d gap=%0d",
                     pos[0], pos[1] - pos[0], elat, elat + 1);
        end
        checks++;
        if ({out_bcd1, out_bcd0, exact} !== {et, eo, eex}) begin
            errors++;
            $display("FAIL back_to_back result: got %h%h ex=%b expected %h%h ex=%b",
                     out_bcd1, out_bcd0, exact, et, eo, eex);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invalid();
        test_random();
        test_reset_mid_search();
        test_start_during_search();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
